// File: rtl/flag_interval_monitor.sv
// flag_interval_monitor: receive-side checker for a periodic flag.
// Measures the clk_p cycle count between successive rising edges of flag_in,
// reports each interval and flags edges that arrive too early or not at all.
// A saturating event counter and a sticky error bit serve status readout.
module flag_interval_monitor #(
  parameter int CNT_W   = 16,
  parameter int EVT_W   = 16,
  parameter int MIN_PRD = 8,
  parameter int MAX_PRD = 12
) (
  input  logic             clk_p,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             flag_in,
  input  logic             clr_stat,
  output logic [CNT_W-1:0] interval,
  output logic             interval_vld,
  output logic             err_early,
  output logic             err_late,
  output logic             err_sticky,
  output logic [EVT_W-1:0] flag_total
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PRD);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PRD);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t           state_q, state_d;
  logic             flag_prev_q, flag_prev_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] interval_q, interval_d;
  logic             vld_q, vld_d;
  logic             early_q, early_d;
  logic             late_q, late_d;
  logic             sticky_q, sticky_d;
  logic [EVT_W-1:0] total_q, total_d;

  logic             evt;
  logic             cnt_evt;

  // Rising edge of flag_in, only counted while monitoring is enabled.
  assign evt = enable & flag_in & ~flag_prev_q;

  // Edge-detect history follows flag_in every cycle, enabled or not.
  always_comb begin
    flag_prev_d = flag_in;
  end

  // Next-state, interval timer and strobe generation.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    interval_d = interval_q;
    vld_d      = 1'b0;
    early_d    = 1'b0;
    late_d     = 1'b0;
    cnt_evt    = 1'b0;
    if (!enable) begin
      // Dropping enable discards any measurement in flight silently.
      state_d = IDLE;
      tmr_d   = '0;
    end else begin
      unique case (state_q)
        // IDLE behaves like ARMED once enabled, so an edge seen in the first
        // enabled cycle (e.g. flag already high at reset release) is kept.
        IDLE, ARMED: begin
          if (evt) begin
            state_d = MEASURE;
            tmr_d   = ONE_C;
            cnt_evt = 1'b1;
          end else begin
            state_d = ARMED;
            tmr_d   = '0;
          end
        end
        MEASURE: begin
          if (evt) begin
            // An edge always wins over a timeout in the same cycle.
            interval_d = tmr_q;
            vld_d      = 1'b1;
            early_d    = (tmr_q < MIN_C);
            tmr_d      = ONE_C;
            cnt_evt    = 1'b1;
          end else if (tmr_q >= MAX_C) begin
            // Window closed without an edge: re-arm for a fresh reference.
            late_d  = 1'b1;
            state_d = ARMED;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + ONE_C;
          end
        end
        default: begin
          state_d = IDLE;
          tmr_d   = '0;
        end
      endcase
    end
  end

  // Statistics: saturating edge count and sticky error, set wins over clear.
  always_comb begin
    total_d  = total_q;
    sticky_d = sticky_q;
    if (clr_stat) begin
      total_d  = cnt_evt ? EVT_W'(1) : '0;
      sticky_d = 1'b0;
    end else if (cnt_evt && !(&total_q)) begin
      total_d = total_q + EVT_W'(1);
    end
    if (early_q || late_q) begin
      sticky_d = 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_p) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      flag_prev_q <= 1'b0;
      tmr_q       <= '0;
      interval_q  <= '0;
      vld_q       <= 1'b0;
      early_q     <= 1'b0;
      late_q      <= 1'b0;
      sticky_q    <= 1'b0;
      total_q     <= '0;
    end else begin
      state_q     <= state_d;
      flag_prev_q <= flag_prev_d;
      tmr_q       <= tmr_d;
      interval_q  <= interval_d;
      vld_q       <= vld_d;
      early_q     <= early_d;
      late_q      <= late_d;
      sticky_q    <= sticky_d;
      total_q     <= total_d;
    end
  end

  assign interval     = interval_q;
  assign interval_vld = vld_q;
  assign err_early    = early_q;
  assign err_late     = late_q;
  assign err_sticky   = sticky_q;
  assign flag_total   = total_q;

endmodule
